// File: rtl/range_seq_pkg.sv
// rtl/range_seq_pkg.sv - shared state encodings, constants and width helper for range_frame_sequencer
package range_seq_pkg;

  localparam int NIBBLES = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD_THR  = 3'd1;
  localparam state_t ST_CAPTURE   = 3'd2;
  localparam state_t ST_WAIT_PEAK = 3'd3;
  localparam state_t ST_NEXT      = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  // Bits needed to index 0..n-1 (at least 1).
  function automatic int cnt_width(input int unsigned n);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/range_seq_watchdog.sv
// rtl/range_seq_watchdog.sv - WAIT_PEAK cycle counter; expired on the LIMIT-th consecutive enabled cycle
module range_seq_watchdog
  import range_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 1048576
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = cnt_width(LIMIT);

  logic [W-1:0] count;

  assign expired = enable && (count == W'(LIMIT - 1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/range_frame_sequencer.sv
// rtl/range_frame_sequencer.sv - frames ADC samples into FFT_LEN captures and sequences peak reports per chirp
// Optional WAIT_PEAK watchdog enabled by defining RANGE_SEQ_TIMEOUT_EN.
module range_frame_sequencer
  import range_seq_pkg::*;
#(
  parameter int unsigned FFT_LEN        = 8192,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] chirp_count_max,
  input  logic [63:0] threshold_i,
  input  logic [63:0] threshold_q,
  input  logic        s_iq_tvalid,
  output logic        m_iq_tvalid,
  output logic        m_iq_tlast,
  output logic        m_iq_first,
  input  logic        m_iq_tready,
  output logic [63:0] counter_id,
  output logic [7:0]  threshold_ctrl_i,
  output logic [7:0]  threshold_ctrl_q,
  input  logic        pk_tvalid,
  input  logic        pk_tlast,
  output logic        pk_tready,
  output logic        busy,
  output logic        done,
  output logic        overrun_err,
  output logic        timeout_err
);

  localparam int CW = cnt_width(FFT_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FFT_LEN - 1);

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [31:0]   frame_cnt;
  logic [31:0]   frame_max;
  logic [63:0]   thr_i_q;
  logic [63:0]   thr_q_q;
  logic [3:0]    nib_idx;
  logic          beat;
  logic          pk_last_xfer;
  logic          wd_expired;

  // Gating with areset keeps the sample strobes low for the whole reset pulse.
  assign m_iq_tvalid  = !areset && (state == ST_CAPTURE) && s_iq_tvalid;
  assign m_iq_first   = m_iq_tvalid && (sample_cnt == '0);
  assign m_iq_tlast   = m_iq_tvalid && (sample_cnt == LAST_IDX);
  assign beat         = m_iq_tvalid && m_iq_tready;
  assign pk_tready    = (state == ST_WAIT_PEAK);
  assign pk_last_xfer = pk_tvalid && pk_tready && pk_tlast;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

`ifdef RANGE_SEQ_TIMEOUT_EN
  logic timeout_q;

  range_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (state != ST_WAIT_PEAK),
    .enable  (state == ST_WAIT_PEAK),
    .expired (wd_expired)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timeout_q <= 1'b0;
    end else if (!abort) begin
      if (state == ST_IDLE && start) begin
        timeout_q <= 1'b0;
      end else if (wd_expired && !pk_last_xfer) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state            <= ST_IDLE;
      sample_cnt       <= '0;
      frame_cnt        <= '0;
      frame_max        <= 32'd1;
      thr_i_q          <= '0;
      thr_q_q          <= '0;
      nib_idx          <= '0;
      counter_id       <= '0;
      threshold_ctrl_i <= '0;
      threshold_ctrl_q <= '0;
      overrun_err      <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD_THR;
            frame_max   <= (chirp_count_max == 32'd0) ? 32'd1 : chirp_count_max;
            thr_i_q     <= threshold_i;
            thr_q_q     <= threshold_q;
            frame_cnt   <= '0;
            sample_cnt  <= '0;
            nib_idx     <= '0;
            overrun_err <= 1'b0;
          end
        end
        ST_LOAD_THR: begin
          threshold_ctrl_i <= {nib_idx, thr_i_q[{nib_idx, 2'b00} +: 4]};
          threshold_ctrl_q <= {nib_idx, thr_q_q[{nib_idx, 2'b00} +: 4]};
          nib_idx          <= nib_idx + 1'b1;
          if (nib_idx == 4'(NIBBLES - 1)) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (beat) begin
            if (sample_cnt == LAST_IDX) begin
              sample_cnt <= '0;
              state      <= ST_WAIT_PEAK;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end else if (s_iq_tvalid && !m_iq_tready) begin
            overrun_err <= 1'b1;
          end
        end
        ST_WAIT_PEAK: begin
          if (pk_last_xfer || wd_expired) state <= ST_NEXT;
        end
        ST_NEXT: begin
          counter_id <= counter_id + 64'd1;
          frame_cnt  <= frame_cnt + 32'd1;
          state      <= (frame_cnt + 32'd1 == frame_max) ? ST_DONE : ST_CAPTURE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// tb/tb_range_frame_sequencer.sv - scoreboard bench for range_frame_sequencer (FFT_LEN=16, TIMEOUT_CYCLES=32)
module tb_range_frame_sequencer;

  localparam int FFT = 16;
  localparam int TMO = 32;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        abort;
  logic [31:0] chirp_count_max;
  logic [63:0] threshold_i;
  logic [63:0] threshold_q;
  logic        s_iq_tvalid;
  logic        m_iq_tvalid;
  logic        m_iq_tlast;
  logic        m_iq_first;
  logic        m_iq_tready;
  logic [63:0] counter_id;
  logic [7:0]  threshold_ctrl_i;
  logic [7:0]  threshold_ctrl_q;
  logic        pk_tvalid;
  logic        pk_tlast;
  logic        pk_tready;
  logic        busy;
  logic        done;
  logic        overrun_err;
  logic        timeout_err;

  typedef struct {
    logic        first;
    logic        last;
    logic [63:0] id;
  } beat_t;

  beat_t       sb[$];
  beat_t       mon_b;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          done_count   = 0;
  int          exp_done     = 0;
  logic [63:0] exp_id       = '0;

  range_frame_sequencer #(
    .FFT_LEN        (FFT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .start            (start),
    .abort            (abort),
    .chirp_count_max  (chirp_count_max),
    .threshold_i      (threshold_i),
    .threshold_q      (threshold_q),
    .s_iq_tvalid      (s_iq_tvalid),
    .m_iq_tvalid      (m_iq_tvalid),
    .m_iq_tlast       (m_iq_tlast),
    .m_iq_first       (m_iq_first),
    .m_iq_tready      (m_iq_tready),
    .counter_id       (counter_id),
    .threshold_ctrl_i (threshold_ctrl_i),
    .threshold_ctrl_q (threshold_ctrl_q),
    .pk_tvalid        (pk_tvalid),
    .pk_tlast         (pk_tlast),
    .pk_tready        (pk_tready),
    .busy             (busy),
    .done             (done),
    .overrun_err      (overrun_err),
    .timeout_err      (timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Output beats are scored against the queue filled by the stimulus.
  always @(negedge aclk) begin
    if (!areset) begin
      if (done) done_count++;
      if (m_iq_tvalid && m_iq_tready) begin
        check_eq("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_b = sb.pop_front();
          check_eq("beat_flags", {62'd0, m_iq_first, m_iq_tlast}, {62'd0, mon_b.first, mon_b.last});
          check_eq("beat_id", counter_id, mon_b.id);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] chirps, input logic [63:0] ti, input logic [63:0] tq);
    logic [7:0] ei;
    logic [7:0] eq;
    chirp_count_max = chirps;
    threshold_i     = ti;
    threshold_q     = tq;
    start           = 1'b1;
    tick();
    start           = 1'b0;
    threshold_i     = ~ti;
    threshold_q     = ~tq;
    chirp_count_max = 32'd7;
    check_eq("busy_after_start", busy, 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      ei = {4'(k), ti[4*k +: 4]};
      eq = {4'(k), tq[4*k +: 4]};
      check_eq("thr_ctrl_i", threshold_ctrl_i, ei);
      check_eq("thr_ctrl_q", threshold_ctrl_q, eq);
    end
  endtask

  task automatic capture_frame(input int nbeats, input int stall_at, input logic [63:0] id);
    beat_t b;
    int    stalls;
    stalls = 0;
    for (int i = 0; i < nbeats; i++) begin
      b.first = (i == 0);
      b.last  = (i == FFT - 1);
      b.id    = id;
      sb.push_back(b);
    end
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      if (stall_at >= 0 && (nbeats - sb.size()) == stall_at && stalls < 3) begin
        m_iq_tready = 1'b0;
        stalls++;
      end else begin
        m_iq_tready = 1'b1;
      end
      s_iq_tvalid = 1'b1;
      tick();
    end
    s_iq_tvalid = 1'b0;
    m_iq_tready = 1'b1;
    check_eq("frame_beats_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic peak_report();
    check_eq("pk_tready_wait", pk_tready, 1);
    pk_tvalid = 1'b1;
    pk_tlast  = 1'b0;
    tick();
    check_eq("pk_discard_still_wait", pk_tready, 1);
    pk_tlast = 1'b1;
    tick();
    pk_tvalid = 1'b0;
    pk_tlast  = 1'b0;
    check_eq("pk_tready_next", pk_tready, 0);
    tick();
    exp_id = exp_id + 64'd1;
    check_eq("counter_id", counter_id, exp_id);
  endtask

  initial begin
    areset          = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    chirp_count_max = '0;
    threshold_i     = '0;
    threshold_q     = '0;
    s_iq_tvalid     = 1'b1;
    m_iq_tready     = 1'b1;
    pk_tvalid       = 1'b0;
    pk_tlast        = 1'b0;
    repeat (3) tick();
    check_eq("rst_m_iq_tvalid", m_iq_tvalid, 0);
    check_eq("rst_counter_id", counter_id, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pk_tready", pk_tready, 0);
    check_eq("rst_thr_ctrl", {threshold_ctrl_i, threshold_ctrl_q}, 0);
    check_eq("rst_errs", {overrun_err, timeout_err}, 0);
    areset      = 1'b0;
    s_iq_tvalid = 1'b0;
    tick();

    // abort beats start in the same cycle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_beats_start", busy, 0);

    // two-frame run, threshold nibble sequence
    do_start(32'd2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    capture_frame(FFT, -1, exp_id);
    peak_report();
    check_eq("mid_run_done", done, 0);
    check_eq("mid_run_busy", busy, 1);
    check_eq("thr_held", threshold_ctrl_i, 8'hF0);
    capture_frame(FFT, -1, exp_id);
    peak_report();
    check_eq("run1_done", done, 1);
    exp_done++;
    check_eq("run1_overrun", overrun_err, 0);
    tick();
    check_eq("run1_idle_done", done, 0);
    check_eq("run1_idle_busy", busy, 0);

    // backpressure at sample 5; chirp_count_max 0 acts as 1
    do_start(32'd0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    capture_frame(FFT, 5, exp_id);
    check_eq("overrun_set", overrun_err, 1);
    peak_report();
    check_eq("run2_done", done, 1);
    exp_done++;
    tick();

    // abort mid-capture, then a normal run
    do_start(32'd1, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0);
    check_eq("overrun_cleared", overrun_err, 0);
    capture_frame(7, -1, exp_id);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_idle", busy, 0);
    check_eq("abort_counter_id", counter_id, exp_id);
    repeat (3) tick();
    check_eq("abort_no_done", done_count, exp_done);
    do_start(32'd1, 64'h0123_4567_89AB_CDEF, 64'h0);
    capture_frame(FFT, -1, exp_id);
    peak_report();
    check_eq("run3_done", done, 1);
    exp_done++;
    tick();

    do_start(32'd1, 64'hDEAD_BEEF_CAFE_F00D, 64'h1);
    capture_frame(FFT, -1, exp_id);
`ifdef RANGE_SEQ_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!timeout_err && n < 100) begin
        tick();
        n++;
      end
      check_eq("timeout_latency", 64'(n), 64'(TMO));
      check_eq("timeout_next", pk_tready, 0);
      tick();
      exp_id = exp_id + 64'd1;
      check_eq("timeout_done", done, 1);
      check_eq("timeout_counter_id", counter_id, exp_id);
      exp_done++;
      tick();
    end
`else
    repeat (40) tick();
    check_eq("wait_indefinite", busy, 1);
    check_eq("timeout_tied", timeout_err, 0);
    peak_report();
    check_eq("run4_done", done, 1);
    exp_done++;
    tick();
`endif
    check_eq("done_count", done_count, exp_done);

    // asynchronous reset while waiting for a peak
    do_start(32'd3, 64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999);
    capture_frame(FFT, -1, exp_id);
    s_iq_tvalid = 1'b1;
    #2 areset = 1'b1;
    #1;
    check_eq("arst_busy_pk", {busy, pk_tready, done}, 0);
    check_eq("arst_counter_id", counter_id, 0);
    check_eq("arst_thr_ctrl", {threshold_ctrl_i, threshold_ctrl_q}, 0);
    check_eq("arst_strobes", {m_iq_tvalid, m_iq_tlast, m_iq_first}, 0);
    check_eq("arst_errs", {overrun_err, timeout_err}, 0);
    tick();
    areset      = 1'b0;
    s_iq_tvalid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/range_frame_sequencer.md
RANGE_FRAME_SEQUENCER -- requirements
Module: range_frame_sequencer

Interface
REQ-001 SHALL have parameter FFT_LEN, default 8192, the number of samples per capture frame; power of two, at least 16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, the WAIT_PEAK watchdog limit in cycles.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a 1-cycle pulse that begins a run.
REQ-006 SHALL have port abort, input, 1 bit: forces return to IDLE.
REQ-007 SHALL have port chirp_count_max, input, 32 bits: frames per run; 0 is treated as 1.
REQ-008 SHALL have ports threshold_i and threshold_q, input, 64 bits each: the peak thresholds to program.
REQ-009 SHALL have port s_iq_tvalid, input, 1 bit: ADC sample valid; there is no backpressure toward the ADC.
REQ-010 SHALL have ports m_iq_tvalid, m_iq_tlast and m_iq_first, output, 1 bit each: the framed sample strobes to the range detector.
REQ-011 SHALL have port m_iq_tready, input, 1 bit: range detector ready.
REQ-012 SHALL have port counter_id, output, 64 bits: the current frame ID.
REQ-013 SHALL have ports threshold_ctrl_i and threshold_ctrl_q, output, 8 bits each: {nibble index, nibble value}.
REQ-014 SHALL have ports pk_tvalid and pk_tlast, input, 1 bit each, and pk_tready, output, 1 bit: the peak report handshake.
REQ-015 SHALL have ports busy, done, overrun_err and timeout_err, output, 1 bit each: status.

Function
REQ-016 SHALL implement the states IDLE, LOAD_THR, CAPTURE, WAIT_PEAK, NEXT and DONE.
REQ-017 SHALL move from IDLE to LOAD_THR on start; start SHALL be ignored in any other state.
REQ-018 In LOAD_THR, SHALL drive threshold_ctrl_x = {k, threshold_x[4k+3:4k]} for k = 0..15, one nibble per cycle, then enter CAPTURE; the last nibble SHALL stay held during CAPTURE.
REQ-019 In CAPTURE, m_iq_tvalid SHALL equal s_iq_tvalid, combinationally.
REQ-020 In CAPTURE, the sample counter SHALL advance only on s_iq_tvalid & m_iq_tready.
REQ-021 m_iq_first SHALL be asserted with sample 0 and m_iq_tlast with sample FFT_LEN-1; after the last sample the block SHALL enter WAIT_PEAK.
REQ-022 s_iq_tvalid asserted while m_iq_tready is low in CAPTURE SHALL set sticky overrun_err; the sample is dropped and the counter does not advance.
REQ-023 pk_tready SHALL be 1 only in WAIT_PEAK.
REQ-024 A pk_tvalid & pk_tready & pk_tlast transfer SHALL cause the transition to NEXT; beats without pk_tlast SHALL be accepted and discarded.
REQ-025 In NEXT (1 cycle), counter_id and the frame count SHALL each increment by 1.
REQ-026 From NEXT, the block SHALL go to DONE if frame count equals max(chirp_count_max, 1), else to CAPTURE; thresholds SHALL NOT be reloaded between frames.
REQ-027 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 chirp_count_max and threshold_x SHALL be sampled on start and held for the whole run.
REQ-030 abort SHALL force IDLE on the next edge from any state and SHALL win over start or pk_tlast in the same cycle; it SHALL NOT assert done.
REQ-031 An abort in mid-CAPTURE SHALL NOT emit m_iq_tlast.
REQ-032 counter_id SHALL wrap at 2^64 - 1 and SHALL be kept across runs; only reset clears it.
REQ-033 overrun_err and timeout_err SHALL clear on the next start.

Reset
REQ-034 On areset, the state SHALL be IDLE; counter_id, the counters, threshold_ctrl_x, done, busy, pk_tready and both error flags SHALL be 0.
REQ-035 While areset is high, m_iq_tvalid, m_iq_tlast and m_iq_first SHALL be 0.

Configuration
REQ-036 With RANGE_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES consecutive cycles in WAIT_PEAK with no tlast transfer SHALL set timeout_err and go to NEXT, so the frame is skipped but counted.
REQ-037 With RANGE_SEQ_TIMEOUT_EN undefined, WAIT_PEAK SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no watchdog logic SHALL be present.

Structure
REQ-038 Package range_seq_pkg SHALL hold the state enum, the NIBBLES=16 constant and the helper function that computes the counter width from FFT_LEN.
REQ-039 Sub-module range_seq_watchdog SHALL contain the WAIT_PEAK counter (clear, enable, expired) and be instantiated only under RANGE_SEQ_TIMEOUT_EN.

Verification
REQ-040 Test 1 (FFT_LEN=16, chirp_count_max=2, continuous valid/ready, one pk_tlast per frame): SHALL produce 2x16 samples with first at 0 and tlast at 15 of each frame, counter_id 0->2, and done exactly once.
REQ-041 Test 2 (threshold_i=64'h0123_4567_89AB_CDEF): threshold_ctrl_i SHALL step 8'h0F, 8'h1E, ... ending at 8'hF0, one value per cycle.
REQ-042 Test 3 (m_iq_tready low for 3 valid cycles at sample 5): overrun_err SHALL be 1 and tlast SHALL still fall on the 16th accepted sample.
REQ-043 Test 4 (abort at sample 7): the next state SHALL be IDLE with no tlast and no done; a following start SHALL run normally.
REQ-044 Test 5 (TIMEOUT_EN, TIMEOUT_CYCLES=32, no pk_tvalid): timeout_err SHALL assert 32 cycles after entering WAIT_PEAK, then NEXT and DONE SHALL follow.
REQ-045 Test 6 (areset asserted mid-WAIT_PEAK): all outputs SHALL be 0 immediately, without waiting for a clock edge.
